// File: rtl/i2c_slave_byte_engine_if.sv
// i2c_slave_byte_engine_if: bus-strobe and byte-buffer bundle between the edge detector, the byte engine and the data buffers
// slave modport: engine side (consumes strobes/sda_in/tx_data, drives sda_oe and the rx/tx/status outputs)
// master modport: driving side (produces strobes/sda_in/tx_data, observes engine outputs)
interface i2c_slave_byte_engine_if #(parameter int BITS = 6);
  logic start_det, stop_det, scl_rise, scl_fall, sda_in;
  logic [7:0] tx_data, rx_data;
  logic sda_oe, rx_valid, tx_req, rw, addressed, overflow;
  logic [BITS:0] byte_count;
  modport slave (
    input start_det, stop_det, scl_rise, scl_fall, sda_in, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, rw, addressed, byte_count, overflow
  );
  modport master (
    output start_det, stop_det, scl_rise, scl_fall, sda_in, tx_data,
    input sda_oe, rx_data, rx_valid, tx_req, rw, addressed, byte_count, overflow
  );
endinterface

// File: rtl/i2c_slave_byte_engine.sv
// i2c_slave_byte_engine: I2C target byte engine decoding START/address/data framing, shifting bytes and driving SDA ACK/read data
// clk, rst: system clock, synchronous active-high reset
// bus: strobes start_det/stop_det/scl_rise/scl_fall, sda_in, tx_data in; sda_oe, rx_data, rx_valid, tx_req, rw, addressed, byte_count, overflow out
module i2c_slave_byte_engine #(
  parameter int BITS = 6,
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input logic clk,
  input logic rst,
  i2c_slave_byte_engine_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT} state_t;
  localparam logic [BITS:0] MAX = {1'b1, {BITS{1'b0}}};
  localparam logic [BITS:0] ONE = (BITS+1)'(1);
  state_t state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] sh_q, rx_data_q, byte_in;
  logic ack_q, sda_oe_q, rx_valid_q, tx_req_q, rw_q, addressed_q, overflow_q;
  logic [BITS:0] byte_count_q;
  assign byte_in = {sh_q[6:0], bus.sda_in};
  // In TX, sh_q holds the not-yet-driven bits left-aligned; bit_cnt_q counts bits already driven.
  // In TX_ACK, bit_cnt_q drops to 0 once the master ACK has been sampled, arming the reload fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      sh_q <= '0;
      ack_q <= 1'b0;
      sda_oe_q <= 1'b0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q <= 1'b0;
      rw_q <= 1'b0;
      addressed_q <= 1'b0;
      byte_count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_req_q <= 1'b0;
      if (bus.start_det) begin
        state_q <= ADDR;
        bit_cnt_q <= '0;
        sda_oe_q <= 1'b0;
        addressed_q <= 1'b0;
        byte_count_q <= '0;
        overflow_q <= 1'b0;
      end else if (bus.stop_det) begin
        state_q <= IDLE;
        sda_oe_q <= 1'b0;
        addressed_q <= 1'b0;
      end else if (bus.scl_rise) begin
        case (state_q)
          ADDR, RX: if (!bit_cnt_q[3]) begin
            sh_q <= byte_in;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7 && state_q == ADDR) begin
              rw_q <= bus.sda_in;
              if (sh_q[6:0] != SLAVE_ADDR) state_q <= WAIT;
            end else if (bit_cnt_q == 4'd7) begin
              ack_q <= byte_count_q != MAX;
              if (byte_count_q != MAX) begin
                rx_data_q <= byte_in;
                rx_valid_q <= 1'b1;
                byte_count_q <= byte_count_q + ONE;
              end else overflow_q <= 1'b1;
            end
          end
          TX_ACK: if (bit_cnt_q[3]) begin
            if (byte_count_q != MAX) byte_count_q <= byte_count_q + ONE;
            if (bus.sda_in) state_q <= WAIT;
            else bit_cnt_q <= '0;
          end
          default: ;
        endcase
      end else if (bus.scl_fall) begin
        case (state_q)
          ADDR: if (bit_cnt_q[3]) begin
            sda_oe_q <= 1'b1;
            addressed_q <= 1'b1;
            state_q <= ADDR_ACK;
          end
          ADDR_ACK, TX_ACK: if (state_q == ADDR_ACK && !rw_q) begin
            sda_oe_q <= 1'b0;
            bit_cnt_q <= '0;
            state_q <= RX;
          end else if (state_q == ADDR_ACK || !bit_cnt_q[3]) begin
            sh_q <= {bus.tx_data[6:0], 1'b0};
            sda_oe_q <= !bus.tx_data[7];
            tx_req_q <= 1'b1;
            bit_cnt_q <= 4'd1;
            state_q <= TX;
          end
          RX: if (bit_cnt_q[3]) begin
            sda_oe_q <= ack_q;
            state_q <= RX_ACK;
          end
          RX_ACK: begin
            sda_oe_q <= 1'b0;
            bit_cnt_q <= '0;
            state_q <= RX;
          end
          TX: if (bit_cnt_q[3]) begin
            sda_oe_q <= 1'b0;
            state_q <= TX_ACK;
          end else begin
            sda_oe_q <= !sh_q[7];
            sh_q <= {sh_q[6:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end
  assign bus.sda_oe = sda_oe_q;
  assign bus.rx_data = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_req = tx_req_q;
  assign bus.rw = rw_q;
  assign bus.addressed = addressed_q;
  assign bus.byte_count = byte_count_q;
  assign bus.overflow = overflow_q;
endmodule
